// File: rtl/adder_pipe_mod.sv
// adder_pipe_mod -- lane-pipelined adder/subtractor with valid/ready flow control.
//
// The WIDTH-bit operation is split into STAGES = WIDTH/LANE lanes. Lane k is
// added in stage k using the carry registered by stage k-1, so the carry chain
// per cycle is only LANE bits long. Operand bits for upper lanes travel
// registered alongside the growing partial result until their stage is reached.
// Every accepted bundle appears at the output exactly STAGES cycles later when
// the consumer is not stalling; a stall freezes the whole pipeline.
//
// Parameters:
//   WIDTH  operand/result width in bits (must be a multiple of LANE)
//   LANE   bits added per pipeline stage (>= 1)
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   operand bundle present
//   in_ready   bundle accepted this cycle when in_valid is also high
//   A, B       operands
//   SUB        1 = A-B (two's complement), 0 = A+B
//   out_valid  result bundle present
//   out_ready  consumer takes the result this cycle
//   S          sum/difference modulo 2^WIDTH
//   COUT       carry out of bit WIDTH-1 (for subtraction: 1 = no borrow)
//
// Optional feature, macro ADDER_PIPE_FLAGS_EN: adds OVF (signed overflow),
// ZERO (S==0) and NEG (S[WIDTH-1]) outputs, registered and aligned with S.

module adder_pipe_mod #(
  parameter int WIDTH = 64,
  parameter int LANE  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             COUT
`ifdef ADDER_PIPE_FLAGS_EN
  ,
  output logic             OVF,
  output logic             ZERO,
  output logic             NEG
`endif
);

  // Guarded so a bad LANE does not trigger a division by zero before the
  // parameter check below gets to report it.
  localparam int STAGES = (LANE >= 1) ? (WIDTH / LANE) : 1;

  if (LANE < 1) begin : g_badLane
    $error("adder_pipe_mod: LANE must be at least 1");
  end else if ((WIDTH % LANE) != 0) begin : g_badWidth
    $error("adder_pipe_mod: WIDTH must be an integer multiple of LANE");
  end

  logic             w_advance;
  logic [WIDTH-1:0] w_bEff;

  // The whole pipeline moves together: it may shift whenever the output slot
  // is empty or is being drained this cycle. in_ready mirrors that directly.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // Subtraction is A + ~B + 1; the +1 enters as the lane-0 carry-in.
  assign w_bEff = SUB ? ~B : B;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    logic                  w_vIn;
    logic                  w_cIn;
    logic [LANE-1:0]       w_aLane;
    logic [LANE-1:0]       w_bLane;
    logic [LANE:0]         w_laneSum;
    logic [(k+1)*LANE-1:0] w_sumNext;
    logic                  r_valid;
    logic                  r_carry;
    logic [(k+1)*LANE-1:0] r_sum;

    // Stage 0 takes its lane straight from the ports; later stages take the
    // lowest pending operand lane and the carry from the previous stage.
    if (k == 0) begin : g_first
      assign w_vIn     = in_valid;
      assign w_cIn     = SUB;
      assign w_aLane   = A[LANE-1:0];
      assign w_bLane   = w_bEff[LANE-1:0];
      assign w_sumNext = w_laneSum[LANE-1:0];
    end else begin : g_next
      assign w_vIn     = g_stage[k-1].r_valid;
      assign w_cIn     = g_stage[k-1].r_carry;
      assign w_aLane   = g_stage[k-1].g_pending.r_aHi[LANE-1:0];
      assign w_bLane   = g_stage[k-1].g_pending.r_bHi[LANE-1:0];
      assign w_sumNext = {w_laneSum[LANE-1:0], g_stage[k-1].r_sum};
    end

    assign w_laneSum = {1'b0, w_aLane} + {1'b0, w_bLane} + {{LANE{1'b0}}, w_cIn};

    // Per-stage valid marks bubbles; data moves with it but is only
    // meaningful when valid is set.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (w_advance) begin
        r_valid <= w_vIn;
        r_carry <= w_laneSum[LANE];
        r_sum   <= w_sumNext;
      end
    end

    // Operand bits of lanes not yet added ride along (skew registers).
    // The last stage has nothing left to carry.
    if (k < STAGES - 1) begin : g_pending
      localparam int HIW = WIDTH - (k + 1) * LANE;
      logic [HIW-1:0] w_aRest;
      logic [HIW-1:0] w_bRest;
      logic [HIW-1:0] r_aHi;
      logic [HIW-1:0] r_bHi;

      if (k == 0) begin : g_srcPorts
        assign w_aRest = A[WIDTH-1:LANE];
        assign w_bRest = w_bEff[WIDTH-1:LANE];
      end else begin : g_srcPrev
        assign w_aRest = g_stage[k-1].g_pending.r_aHi[HIW+LANE-1:LANE];
        assign w_bRest = g_stage[k-1].g_pending.r_bHi[HIW+LANE-1:LANE];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_aHi <= '0;
          r_bHi <= '0;
        end else if (w_advance) begin
          r_aHi <= w_aRest;
          r_bHi <= w_bRest;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign S         = g_stage[STAGES-1].r_sum;
  assign COUT      = g_stage[STAGES-1].r_carry;

`ifdef ADDER_PIPE_FLAGS_EN
  logic w_ovfNext;
  logic w_zeroNext;
  logic w_negNext;
  logic r_ovf;
  logic r_zero;
  logic r_neg;

  // The top lane is added in the last stage, so its sign bits are available
  // there. Overflow: operands (A and effective B) share a sign that the
  // result does not.
  assign w_ovfNext  = (g_stage[STAGES-1].w_aLane[LANE-1] == g_stage[STAGES-1].w_bLane[LANE-1]) &&
                      (g_stage[STAGES-1].w_laneSum[LANE-1] != g_stage[STAGES-1].w_aLane[LANE-1]);
  assign w_zeroNext = (g_stage[STAGES-1].w_sumNext == '0);
  assign w_negNext  = g_stage[STAGES-1].w_laneSum[LANE-1];

  // Loaded under the same enable as the last stage so flags stay aligned
  // with S and hold during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_advance) begin
      r_ovf  <= w_ovfNext;
      r_zero <= w_zeroNext;
      r_neg  <= w_negNext;
    end
  end

  assign OVF  = r_ovf;
  assign ZERO = r_zero;
  assign NEG  = r_neg;
`endif

endmodule

// File: tb/tb_adder_pipe_mod.sv
// tb_adder_pipe_mod -- self-checking bench for adder_pipe_mod (WIDTH=64, LANE=16).
// Directed vectors come from a local table; streaming traffic is checked by a
// scoreboard fed from a plain-arithmetic reference model.

module tb_adder_pipe_mod;

  localparam int LAT = 4;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } resT;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] expS;
    logic        expCout;
    logic        expOvf;
    logic        expZero;
    logic        expNeg;
  } vecT;

  typedef struct {
    resT res;
    int  stamp;
  } sbT;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic        SUB;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] S;
  logic        COUT;
`ifdef ADDER_PIPE_FLAGS_EN
  logic        OVF;
  logic        ZERO;
  logic        NEG;
`endif

  int  nCompared;
  int  nMismatched;
  int  cycleCount;
  bit  chkLatency;
  sbT  sbQ[$];
  vecT vecs[8];

  adder_pipe_mod #(.WIDTH(64), .LANE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .COUT      (COUT)
`ifdef ADDER_PIPE_FLAGS_EN
    ,
    .OVF       (OVF),
    .ZERO      (ZERO),
    .NEG       (NEG)
`endif
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time-stamp accepted bundles.
  initial begin
    cycleCount = 0;
    forever begin
      @(posedge clk);
      cycleCount++;
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain wide arithmetic; subtraction borrow taken from an
  // unsigned magnitude comparison.
  function automatic resT refModel(input logic [63:0] a, input logic [63:0] b, input logic sub);
    resT         r;
    logic [64:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    if (sub) begin
      r.s    = a - b;
      r.cout = (a >= b);
      r.ovf  = (a[63] != b[63]) && (r.s[63] != a[63]);
    end else begin
      r.s    = wide[63:0];
      r.cout = wide[64];
      r.ovf  = (a[63] == b[63]) && (r.s[63] != a[63]);
    end
    r.zero = (r.s == 64'd0);
    r.neg  = r.s[63];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, return 1 time unit after it.
  task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] b,
                               input logic sub, input logic ordy);
    in_valid  = v;
    A         = a;
    B         = b;
    SUB       = sub;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pickOperand();
    logic [63:0] r;
    case ($urandom_range(0, 4))
      0:       r = 64'hFFFF_FFFF_FFFF_FFFF;
      1:       r = 64'h8000_0000_0000_0000;
      2:       r = 64'd0;
      default: r = {$urandom(), $urandom()};
    endcase
    return r;
  endfunction

  // Stop offering input and wait (bounded) until every accepted bundle left.
  task automatic drain(input string name);
    int waited;
    waited    = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sbQ.size() != 0 || out_valid) && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput(name, 64'(sbQ.size()), 64'd0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin : monitor
    sbT          item;
    logic        heldValid;
    logic [63:0] heldS;
    logic        heldC;
    heldValid = 1'b0;
    heldS     = '0;
    heldC     = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sbQ.delete();
        heldValid = 1'b0;
      end else begin
        if (heldValid) begin
          checkOutput("hold_valid", 64'(out_valid), 64'd1);
          checkOutput("hold_S", S, heldS);
          checkOutput("hold_COUT", 64'(COUT), 64'(heldC));
        end
        if (out_valid && out_ready) begin
          if (sbQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL unexpected_result: got S=0x%0h, expected no result", S);
          end else begin
            item = sbQ.pop_front();
            checkOutput("sb_S", S, item.res.s);
            checkOutput("sb_COUT", 64'(COUT), 64'(item.res.cout));
`ifdef ADDER_PIPE_FLAGS_EN
            checkOutput("sb_OVF", 64'(OVF), 64'(item.res.ovf));
            checkOutput("sb_ZERO", 64'(ZERO), 64'(item.res.zero));
            checkOutput("sb_NEG", 64'(NEG), 64'(item.res.neg));
`endif
            if (chkLatency) checkOutput("sb_latency", 64'(cycleCount - item.stamp), 64'(LAT));
          end
        end
        heldValid = out_valid && !out_ready;
        heldS     = S;
        heldC     = COUT;
        if (in_valid && in_ready) begin
          item.res   = refModel(A, B, SUB);
          item.stamp = cycleCount;
          sbQ.push_back(item);
        end
      end
    end
  end

  initial begin : main
    logic [15:0] seenMask;
    nCompared   = 0;
    nMismatched = 0;
    chkLatency  = 1'b1;
    reset       = 1'b1;
    in_valid    = 1'b0;
    A           = '0;
    B           = '0;
    SUB         = 1'b0;
    out_ready   = 1'b1;

    vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'd5, 64'd5, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_S", S, 64'd0);
    checkOutput("reset_COUT", 64'(COUT), 64'd0);
    reset = 1'b0;
    checkOutput("ready_after_reset", 64'(in_ready), 64'd1);

    // Directed table: one bundle each, checked exactly LAT edges after acceptance.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d_early_valid", i), 64'(out_valid), 64'd0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("vec%0d_S", i), S, vecs[i].expS);
      checkOutput($sformatf("vec%0d_COUT", i), 64'(COUT), 64'(vecs[i].expCout));
`ifdef ADDER_PIPE_FLAGS_EN
      checkOutput($sformatf("vec%0d_OVF", i), 64'(OVF), 64'(vecs[i].expOvf));
      checkOutput($sformatf("vec%0d_ZERO", i), 64'(ZERO), 64'(vecs[i].expZero));
      checkOutput($sformatf("vec%0d_NEG", i), 64'(NEG), 64'(vecs[i].expNeg));
`endif
    end

    // Ten back-to-back random bundles: results on edges 4..13.
    seenMask = '0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(c < 10, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'b1);
      seenMask[c] = out_valid;
    end
    checkOutput("burst_valid_pattern", 64'(seenMask), 64'h1FF8);
    drain("burst_drain");

    // Streaming with a six-cycle consumer stall.
    chkLatency = 1'b0;
    for (int c = 0; c < 14; c++) begin
      applyStimulus(1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                    !(c >= 5 && c < 11));
      if (c >= 5 && c < 11) begin
        checkOutput($sformatf("stall%0d_out_valid", c), 64'(out_valid), 64'd1);
        checkOutput($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
      end
    end
    drain("stall_drain");

    // Random traffic with random bubbles and backpressure.
    for (int c = 0; c < 300; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2) != 0);
    end
    drain("random_drain");

    // Reset with three bundles in flight behind one at the output.
    chkLatency = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 64'(16 * (i + 1)), 64'd32, 1'b0, 1'b1);
    end
    in_valid = 1'b0;
    checkOutput("prereset_valid", 64'(out_valid), 64'd1);
    checkOutput("prereset_S", S, 64'h30);
    reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_S", S, 64'd0);
    checkOutput("midreset_COUT", 64'(COUT), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("stale%0d_out_valid", c), 64'(out_valid), 64'd0);
    end
    applyStimulus(1'b1, 64'h1234, 64'd1, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("postreset_valid", 64'(out_valid), 64'd1);
    checkOutput("postreset_S", S, 64'h1233);
    checkOutput("postreset_COUT", 64'(COUT), 64'd1);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/adder_pipe_mod.md
ADDER_PIPE_MOD -- requirements
Module: adder_pipe_mod

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL provide parameter LANE, default 16, bits added per pipeline stage; STAGES = WIDTH/LANE.
REQ-003 SHALL provide port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide port in_valid, input, 1, operand bundle present.
REQ-006 SHALL provide port in_ready, output, 1, block accepts bundle this cycle.
REQ-007 SHALL provide ports A and B, input, WIDTH, signed operands.
REQ-008 SHALL provide port SUB, input, 1, 1 = A-B (two's complement), 0 = A+B.
REQ-009 SHALL provide port out_valid, output, 1, result bundle present.
REQ-010 SHALL provide port out_ready, input, 1, consumer takes bundle this cycle.
REQ-011 SHALL provide port S, output, WIDTH, signed sum/difference mod 2^WIDTH.
REQ-012 SHALL provide port COUT, output, 1, carry out of bit WIDTH-1 (for SUB=1: 1 means no borrow).

Function
REQ-013 SHALL reject elaboration when WIDTH is not an integer multiple of LANE or LANE < 1.
REQ-014 SHALL complement B bitwise and inject SUB as carry-in of lane 0 when SUB=1.
REQ-015 SHALL compute lane k (bits k*LANE..k*LANE+LANE-1) in stage k, using the carry registered from stage k-1.
REQ-016 SHALL skew operands: upper-lane operand bits travel registered alongside the partial result until their stage.
REQ-017 SHALL give a latency of exactly STAGES cycles from accepted input to out_valid with no backpressure.
REQ-018 SHALL sustain one accepted bundle per cycle when out_ready is held 1.
REQ-019 SHALL advance the whole pipeline when advance = !out_valid || out_ready; otherwise hold every stage register.
REQ-020 SHALL drive in_ready = advance (combinational, no dependence on in_valid).
REQ-021 SHALL accept a bundle only on a cycle where in_valid && in_ready; per-stage valid bits mark bubbles.
REQ-022 SHALL keep S, COUT (and flags) stable while out_valid=1 and out_ready=0.
REQ-023 SHALL deliver results strictly in acceptance order, no drops, no duplicates.
REQ-024 SHALL wrap silently on overflow (S modulo 2^WIDTH); COUT reflects the unsigned carry.

Reset
REQ-025 SHALL, on reset assertion, immediately clear all stage valid bits, out_valid=0, S=0, COUT=0, flags=0, regardless of clk.
REQ-026 SHALL discard all in-flight bundles on reset mid-operation; none emerge after release.
REQ-027 SHALL present in_ready=1 from the first cycle after reset release.

Configuration
REQ-028 SHALL honour macro ADDER_PIPE_FLAGS_EN.
REQ-029 SHALL, with ADDER_PIPE_FLAGS_EN defined, add outputs OVF (signed overflow: operand sign-equality rule on A and effective B), ZERO (S==0), NEG (S[WIDTH-1]), registered and aligned with S.
REQ-030 SHALL, without ADDER_PIPE_FLAGS_EN, omit OVF/ZERO/NEG ports and their logic; all other behaviour identical.

Verification (WIDTH=64, LANE=16, STAGES=4)
REQ-031 SHALL verify: A=0x00000000FFFFFFFF, B=1, SUB=0, out_ready=1 -> after 4 cycles S=0x0000000100000000, COUT=0, ZERO=0.
REQ-032 SHALL verify: A=5, B=5, SUB=1 -> S=0, COUT=1, ZERO=1, OVF=0; A=0x7FFFFFFFFFFFFFFF, B=1, SUB=0 -> S=0x8000000000000000, OVF=1, NEG=1.
REQ-033 SHALL verify: A=0xFFFFFFFFFFFFFFFF, B=1, SUB=0 -> S=0, COUT=1 (carry ripples through all four lanes).
REQ-034 SHALL verify: 10 back-to-back bundles with out_ready=1 -> 10 results on consecutive cycles 4..13, matching reference model, in order.
REQ-035 SHALL verify: out_ready=0 for 6 cycles while streaming -> in_ready falls once out_valid=1, S held constant, no bundle lost after out_ready=1.
REQ-036 SHALL verify: reset asserted with 3 bundles in flight -> out_valid=0 and S=0 immediately; no stale result after release; next bundle arrives 4 cycles after acceptance.
